// File: rtl/qpu_measure_unit.sv
// qpu_measure_unit
//
// Projective measurement stage for the 2-qubit state-vector core. A request
// snapshots the four signed 8-bit real amplitudes, squares them into
// probabilities with a running cumulative sum, draws a threshold scaled from
// an internal 16-bit Galois LFSR, picks the first basis state whose
// cumulative probability exceeds the threshold, and hands back the measured
// index together with a collapsed state vector for writeback.
//
// Parameters:
//   AMP_ONE  amplitude placed at the selected index of the collapsed vector
//   SEED     LFSR value after reset (zero is replaced by 16'h0001)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   state_flat      {a0,a1,a2,a3}, signed 8-bit each, a0 in [31:24]
//   start           measurement request, taken only while in_ready=1
//   in_ready        high only while idle
//   lfsr_seed_load  load lfsr_seed into the LFSR this cycle (any state)
//   lfsr_seed       seed value, zero loads 16'h0001
//   result_valid    result available, held until result_ready
//   result_ready    consumer accepts the result
//   result          measured basis index 0..3
//   result_err      all amplitudes were zero, result forced to 0
//   collapsed_flat  collapsed vector, same packing as state_flat
module qpu_measure_unit #(
    parameter int          AMP_ONE = 10,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] state_flat,
    input  logic        start,
    output logic        in_ready,
    input  logic        lfsr_seed_load,
    input  logic [15:0] lfsr_seed,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [1:0]  result,
    output logic        result_err,
    output logic [31:0] collapsed_flat
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [7:0]  AMP_BYTE  = 8'(AMP_ONE);

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        DRAW,
        SELECT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       snap_q, snap_d;
    logic [3:0][16:0]  cum_q, cum_d;
    logic [1:0]        idx_q, idx_d;
    logic [16:0]       thr_q, thr_d;
    logic              err_q, err_d;
    logic [1:0]        sel_q, sel_d;
    logic              found_q, found_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [1:0]        result_q, result_d;
    logic              result_err_q, result_err_d;
    logic [31:0]       collapsed_q, collapsed_d;

    // Datapath helpers shared by the state machine.
    logic [7:0]  amp_cur;
    logic [15:0] amp_ext;
    logic [15:0] sq_cur;
    logic [16:0] cum_prev;
    logic [32:0] lfsr_ext;
    logic [32:0] total_ext;
    logic [16:0] thr_cur;
    logic [15:0] lfsr_step;
    logic [1:0]  sel_now;
    logic        found_now;

    // Amplitude for the current SQUARE index, taken from the snapshot so the
    // live input can change freely while a measurement runs.
    always_comb begin
        amp_cur = 8'h00;
        case (idx_q)
            2'd0:    amp_cur = snap_q[31:24];
            2'd1:    amp_cur = snap_q[23:16];
            2'd2:    amp_cur = snap_q[15:8];
            default: amp_cur = snap_q[7:0];
        endcase
    end

    // Squared magnitude. Sign-extending to 16 bits first makes the 16-bit
    // product exact; the largest value is 16384 (a = -128), so bit 15 is
    // always zero and the value is the 15-bit probability.
    assign amp_ext  = {{8{amp_cur[7]}}, amp_cur};
    assign sq_cur   = amp_ext * amp_ext;
    assign cum_prev = (idx_q == 2'd0) ? 17'd0 : cum_q[idx_q - 2'd1];

    // Threshold = floor(r * total / 2^16), which is strictly below total for
    // any nonzero total because r < 2^16.
    assign lfsr_ext  = {17'd0, lfsr_q};
    assign total_ext = {16'd0, cum_q[3]};
    assign thr_cur   = 17'((lfsr_ext * total_ext) >> 16);

    // One step of the right-shifting Galois LFSR. A nonzero state never maps
    // to zero, so the register can only hold zero if loaded with it, and
    // loads of zero are redirected to 1.
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

    // LFSR next state: an external seed load wins over the DRAW advance. The
    // DRAW threshold is computed from lfsr_q, so it always sees the value
    // held before the load.
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_seed_load) begin
            lfsr_d = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;
        end else if (state_q == DRAW) begin
            lfsr_d = lfsr_step;
        end
    end

    // Main control: next state plus all datapath register updates.
    // SELECT keeps the first index whose cumulative sum exceeds the
    // threshold; a zero-probability entry has the same cumulative sum as its
    // predecessor, so it can never be the first to exceed it. With an
    // all-zero vector nothing is ever found and the cleared sel of 0 stands.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        cum_d        = cum_q;
        idx_d        = idx_q;
        thr_d        = thr_q;
        err_d        = err_q;
        sel_d        = sel_q;
        found_d      = found_q;
        result_d     = result_q;
        result_err_d = result_err_q;
        collapsed_d  = collapsed_q;
        sel_now      = sel_q;
        found_now    = found_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = state_flat;
                    cum_d   = '0;
                    idx_d   = 2'd0;
                    thr_d   = 17'd0;
                    err_d   = 1'b0;
                    sel_d   = 2'd0;
                    found_d = 1'b0;
                    state_d = SQUARE;
                end
            end

            SQUARE: begin
                cum_d[idx_q] = cum_prev + {1'b0, sq_cur};
                idx_d        = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DRAW;
                end
            end

            DRAW: begin
                thr_d   = thr_cur;
                err_d   = (cum_q[3] == 17'd0);
                idx_d   = 2'd0;
                state_d = SELECT;
            end

            SELECT: begin
                if (!found_q && (thr_q < cum_q[idx_q])) begin
                    sel_now   = idx_q;
                    found_now = 1'b1;
                end
                sel_d   = sel_now;
                found_d = found_now;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    result_d     = sel_now;
                    result_err_d = err_q;
                    case (sel_now)
                        2'd0:    collapsed_d = {AMP_BYTE, 24'd0};
                        2'd1:    collapsed_d = {8'd0, AMP_BYTE, 16'd0};
                        2'd2:    collapsed_d = {16'd0, AMP_BYTE, 8'd0};
                        default: collapsed_d = {24'd0, AMP_BYTE};
                    endcase
                    state_d = DONE;
                end
            end

            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any measurement in flight
    // and reloads the LFSR from SEED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_q       <= 32'd0;
            cum_q        <= '0;
            idx_q        <= 2'd0;
            thr_q        <= 17'd0;
            err_q        <= 1'b0;
            sel_q        <= 2'd0;
            found_q      <= 1'b0;
            lfsr_q       <= SEED_EFF;
            result_q     <= 2'd0;
            result_err_q <= 1'b0;
            collapsed_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            cum_q        <= cum_d;
            idx_q        <= idx_d;
            thr_q        <= thr_d;
            err_q        <= err_d;
            sel_q        <= sel_d;
            found_q      <= found_d;
            lfsr_q       <= lfsr_d;
            result_q     <= result_d;
            result_err_q <= result_err_d;
            collapsed_q  <= collapsed_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign result_valid   = (state_q == DONE);
    assign result         = result_q;
    assign result_err     = result_err_q;
    assign collapsed_flat = collapsed_q;

endmodule

// File: tb/tb_qpu_measure_unit.sv
// tb_qpu_measure_unit
//
// Self-checking bench for qpu_measure_unit. Expected results come from a
// probability-level reference model: squared amplitudes, a scaled threshold
// from a modelled LFSR, and a walk over the cumulative distribution.
module tb_qpu_measure_unit;

    localparam int          AMP_ONE = 10;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] state_flat;
    logic        start;
    logic        in_ready;
    logic        lfsr_seed_load;
    logic [15:0] lfsr_seed;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  result;
    logic        result_err;
    logic [31:0] collapsed_flat;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [15:0] lfsrModel;

    qpu_measure_unit #(
        .AMP_ONE (AMP_ONE),
        .SEED    (SEED)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .state_flat     (state_flat),
        .start          (start),
        .in_ready       (in_ready),
        .lfsr_seed_load (lfsr_seed_load),
        .lfsr_seed      (lfsr_seed),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result         (result),
        .result_err     (result_err),
        .collapsed_flat (collapsed_flat)
    );

    always #5 clk = ~clk;

    // Galois LFSR step, x^16+x^14+x^13+x^11+1, right shift.
    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Measurement reference: weight each basis state by a_i^2, scale the
    // random draw onto [0,total) and return the state whose cumulative
    // probability interval contains it.
    function automatic void modelMeasure(input logic [31:0] flat, input logic [15:0] r,
                                         output logic [1:0] idx, output logic err);
        int p[4];
        int total;
        int cum;
        longint thr;
        logic signed [7:0] a;
        logic found;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            a = flat[31 - 8 * i -: 8];
            p[i] = int'(a) * int'(a);
            total += p[i];
        end
        thr = (longint'(r) * longint'(total)) / 65536;
        err = (total == 0);
        idx = 2'd0;
        found = 1'b0;
        cum = 0;
        for (int i = 0; i < 4; i++) begin
            cum += p[i];
            if (!found && total != 0 && thr < longint'(cum)) begin
                idx = 2'(i);
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] expCollapsed(input logic [1:0] idx);
        logic [31:0] v;
        v = 32'(AMP_ONE) << (8 * (3 - int'(idx)));
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadSeed(input logic [15:0] s);
        lfsr_seed      = s;
        lfsr_seed_load = 1'b1;
        stepCycle();
        lfsr_seed_load = 1'b0;
        lfsrModel = (s == 16'h0000) ? 16'h0001 : s;
    endtask

    // One complete measurement with result_ready held high; checks latency,
    // all result fields, the return to idle and that results persist.
    task automatic applyStimulus(input logic [31:0] flat, input string tag,
                                 output logic [1:0] gotIdx);
        logic [1:0] eIdx;
        logic       eErr;
        int         lat;
        modelMeasure(flat, lfsrModel, eIdx, eErr);
        lfsrModel = lfsrNext(lfsrModel);
        lat = 0;
        while (!in_ready && lat < 30) begin
            stepCycle();
            lat++;
        end
        state_flat   = flat;
        result_ready = 1'b1;
        start        = 1'b1;
        stepCycle();
        start      = 1'b0;
        state_flat = $urandom;
        lat = 1;
        while (!result_valid && lat < 40) begin
            stepCycle();
            lat++;
        end
        gotIdx = result;
        checkOutput({tag, "/latency"}, 32'(lat), 32'd10);
        checkOutput({tag, "/result"}, {30'd0, result}, {30'd0, eIdx});
        checkOutput({tag, "/err"}, {31'd0, result_err}, {31'd0, eErr});
        checkOutput({tag, "/collapsed"}, collapsed_flat, expCollapsed(eIdx));
        stepCycle();
        checkOutput({tag, "/idle_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "/idle_valid"}, {31'd0, result_valid}, 32'd0);
        checkOutput({tag, "/result_held"}, {30'd0, result}, {30'd0, eIdx});
    endtask

    initial begin
        logic [1:0]  gotIdx;
        logic [1:0]  eIdx;
        logic        eErr;
        logic [31:0] flat;
        logic [15:0] s;
        int          cnt[4];
        int          lat;

        reset          = 1'b1;
        state_flat     = 32'd0;
        start          = 1'b0;
        lfsr_seed_load = 1'b0;
        lfsr_seed      = 16'd0;
        result_ready   = 1'b0;
        lfsrModel      = SEED;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst/in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst/valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stepCycle();
        checkOutput("rst/result", {30'd0, result}, 32'd0);
        checkOutput("rst/err", {31'd0, result_err}, 32'd0);
        checkOutput("rst/collapsed", collapsed_flat, 32'd0);

        // |00> always collapses to index 0.
        for (int n = 0; n < 20; n++) begin
            applyStimulus(32'h0A000000, "basis0", gotIdx);
            checkOutput("basis0/const", {30'd0, gotIdx}, 32'd0);
        end

        // Equal superposition of |00> and |10>, seeded draws.
        loadSeed(16'h8000);
        applyStimulus(32'h05000500, "seed8000", gotIdx);
        checkOutput("seed8000/const", {30'd0, gotIdx}, 32'd2);
        loadSeed(16'h0001);
        applyStimulus(32'h05000500, "seed0001", gotIdx);
        checkOutput("seed0001/const", {30'd0, gotIdx}, 32'd0);

        // Distribution over many draws.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(32'h05000500, "dist", gotIdx);
            cnt[gotIdx]++;
        end
        checkOutput("dist/idx1", 32'(cnt[1]), 32'd0);
        checkOutput("dist/idx3", 32'(cnt[3]), 32'd0);
        checkOutput("dist/balance", {31'd0, (cnt[0] >= 400 && cnt[0] <= 600)}, 32'd1);

        // Single negative amplitude and the -128 extreme.
        applyStimulus(32'h000000F6, "neg3", gotIdx);
        checkOutput("neg3/const", {30'd0, gotIdx}, 32'd3);
        applyStimulus(32'h80808080, "max4", gotIdx);
        applyStimulus(32'h00800000, "max1", gotIdx);
        checkOutput("max1/const", {30'd0, gotIdx}, 32'd1);

        // All-zero vector: forced result and one LFSR advance (0x8000 -> 0x4000
        // turns the next {5,0,5,0} draw into threshold 12 -> index 0).
        loadSeed(16'h8000);
        applyStimulus(32'h00000000, "zero", gotIdx);
        checkOutput("zero/const", {30'd0, gotIdx}, 32'd0);
        applyStimulus(32'h05000500, "after_zero", gotIdx);
        checkOutput("after_zero/const", {30'd0, gotIdx}, 32'd0);

        // Seed of zero loads 1.
        loadSeed(16'h0000);
        applyStimulus(32'h05000500, "seed0", gotIdx);
        checkOutput("seed0/const", {30'd0, gotIdx}, 32'd0);

        // Back-pressure: hold result_ready low, pulse start during DONE.
        flat = 32'h07FD0002;
        modelMeasure(flat, lfsrModel, eIdx, eErr);
        lfsrModel = lfsrNext(lfsrModel);
        state_flat   = flat;
        result_ready = 1'b0;
        start        = 1'b1;
        stepCycle();
        start = 1'b0;
        lat = 1;
        while (!result_valid && lat < 40) begin
            stepCycle();
            lat++;
        end
        checkOutput("hold/latency", 32'(lat), 32'd10);
        for (int k = 0; k < 5; k++) begin
            start      = (k == 2);
            state_flat = $urandom;
            stepCycle();
            checkOutput("hold/in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold/valid", {31'd0, result_valid}, 32'd1);
            checkOutput("hold/result", {30'd0, result}, {30'd0, eIdx});
            checkOutput("hold/collapsed", collapsed_flat, expCollapsed(eIdx));
        end
        start        = 1'b0;
        result_ready = 1'b1;
        stepCycle();
        checkOutput("hold/release_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("hold/release_valid", {31'd0, result_valid}, 32'd0);
        stepCycle();
        checkOutput("hold/no_queue", {31'd0, in_ready}, 32'd1);
        applyStimulus(32'h000000F6, "after_hold", gotIdx);

        // Seed load during DRAW: draw uses old LFSR, LFSR then equals seed.
        flat = 32'h05000500;
        modelMeasure(flat, lfsrModel, eIdx, eErr);
        lfsrModel = 16'h8000;
        state_flat = flat;
        start      = 1'b1;
        stepCycle();
        start = 1'b0;
        lat = 1;
        repeat (4) begin
            stepCycle();
            lat++;
        end
        lfsr_seed      = 16'h8000;
        lfsr_seed_load = 1'b1;
        stepCycle();
        lat++;
        lfsr_seed_load = 1'b0;
        while (!result_valid && lat < 40) begin
            stepCycle();
            lat++;
        end
        checkOutput("drawload/latency", 32'(lat), 32'd10);
        checkOutput("drawload/result", {30'd0, result}, {30'd0, eIdx});
        stepCycle();
        applyStimulus(32'h05000500, "after_drawload", gotIdx);
        checkOutput("after_drawload/const", {30'd0, gotIdx}, 32'd2);

        // Randomized vectors with occasional reseeding.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                loadSeed(s);
            end
            flat = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 2) == 0) flat[8 * b +: 8] = 8'h00;
            end
            applyStimulus(flat, "rand", gotIdx);
        end

        // Reset in cycle 6 of a measurement.
        applyStimulus(32'h00000A00, "pre_reset", gotIdx);
        state_flat = 32'h0A000000;
        start      = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (5) stepCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst/in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst/valid", {31'd0, result_valid}, 32'd0);
        checkOutput("midrst/result", {30'd0, result}, 32'd0);
        checkOutput("midrst/err", {31'd0, result_err}, 32'd0);
        checkOutput("midrst/collapsed", collapsed_flat, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lfsrModel = SEED;
        stepCycle();
        applyStimulus(32'h05000500, "after_reset", gotIdx);
        checkOutput("after_reset/const", {30'd0, gotIdx}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/qpu_measure_unit.md
# qpu_measure_unit

Projective measurement stage directly downstream of the 2-qubit state-vector core. It snapshots the four signed 8-bit real amplitudes and computes the squared-magnitude probabilities. It draws a pseudo-random threshold from an internal LFSR, selects one basis state, and returns the measured index plus a collapsed state vector for writeback into the core.

## Interface
- AMP_ONE, 10: amplitude written at the selected index of the collapsed vector; matches the core's |00⟩ init scale.
- SEED, 16'hACE1: LFSR value after reset; a zero value is replaced by 16'h0001.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- state_flat  in  32  amplitudes {a0,a1,a2,a3}, each signed 8-bit; a0 = [31:24], a3 = [7:0].
- start  in  1  measurement request; accepted only when in_ready=1.
- in_ready  out  1  high only in IDLE.
- lfsr_seed_load  in  1  load lfsr_seed into the LFSR this cycle.
- lfsr_seed  in  16  seed value; 0 loads 16'h0001.
- result_valid  out  1  measurement result available; held until accepted.
- result_ready  in  1  consumer accepts the result when high together with result_valid.
- result  out  2  measured basis index 0..3.
- result_err  out  1  all amplitudes were zero; the result is forced.
- collapsed_flat  out  32  collapsed vector in the same packing as state_flat.

## Operation
- FSM states: IDLE, SQUARE, DRAW, SELECT, DONE.
- IDLE: in_ready=1. On start, latch state_flat into a snapshot, clear the accumulators, and go to SQUARE. state_flat is not sampled again during the measurement.
- SQUARE: 4 cycles, one amplitude per cycle in order 0..3.
  - p_i = a_i*a_i, unsigned 15-bit; the maximum is 16384 for a_i=-128.
  - cum_i = running sum of p_0..p_i, unsigned 17-bit.
  - total = cum_3.
- DRAW: 1 cycle.
  - r = current LFSR contents.
  - thr = (r * total) >> 16: 16x17 unsigned multiply, 33-bit product, keep bits [32:16].
  - thr is always < total when total>0.
  - The LFSR then advances one step.
  - err = (total==0).
- SELECT: 4 cycles, index i = 0..3. sel = smallest i with thr < cum_i. Entries with p_i=0 are never selected. If err, sel = 0.
- DONE:
  - result = sel.
  - result_err = err.
  - collapsed_flat: AMP_ONE (positive, sign discarded) at index sel, 0 elsewhere. When err, this gives AMP_ONE at index 0.
  - result_valid=1. On result_valid && result_ready, go to IDLE.
- LFSR: 16-bit Galois, right shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Advances only in DRAW.
  - Never holds zero.
- lfsr_seed_load is honoured in any state. It has priority over the DRAW advance in the same cycle; that DRAW still uses the pre-load value for r.
- start outside IDLE is ignored. It is not queued.

## Timing
- Reset values:
  - FSM=IDLE, in_ready=1.
  - result_valid=0, result=0, result_err=0.
  - collapsed_flat=0.
  - LFSR=SEED (or 1 if SEED=0).
  - Snapshot and accumulators = 0.
- Accept edge = cycle 0. SQUARE covers cycles 1-4, DRAW cycle 5, SELECT cycles 6-9. result_valid rises after the edge ending cycle 9, i.e. visible in cycle 10.
- Fixed latency of 10 cycles, independent of data and of err.
- result, result_err and collapsed_flat are registered. They are stable for the whole time result_valid=1, and they hold their last values after the handshake until the next DONE.
- Handshake at cycle n: result_valid=0 and in_ready=1 in cycle n+1. The earliest next accept is cycle n+1.
- Back-to-back throughput: one measurement per 11 cycles when result_ready is held high.
- Reset mid-operation: immediate return to the reset values. The partial measurement is discarded and the LFSR reloads SEED.

## Test plan
- After reset, state_flat={10,0,0,0}, start, result_ready=1: result_valid is seen exactly 10 cycles after accept, with result=0, err=0, collapsed_flat={10,0,0,0}. Repeat 20 times: always result=0.
- state_flat={5,0,5,0} (total 50):
  - Seed 16'h8000 gives thr=25 -> result=2, collapsed {0,0,10,0}.
  - Seed 16'h0001 gives thr=0 -> result=0.
  - Over 1000 runs the distribution is about 50/50 between index 0 and 2, and index 1/3 are never seen.
- state_flat={0,0,0,-10}, any seed: result=3, collapsed_flat={0,0,0,+10}. With {-128,...} no overflow occurs (p=16384).
- state_flat=0: result=0, result_err=1, collapsed_flat={10,0,0,0}, latency still 10. The LFSR still advances once.
- Hold result_ready=0 for 5 cycles and pulse start during DONE:
  - Outputs stay stable and in_ready stays 0; the start is ignored.
  - After result_ready=1 the FSM returns to IDLE, and a new start the next cycle is accepted.
- Assert reset at cycle 6 of a measurement: all outputs return to reset values asynchronously. A seed load during DRAW: r uses the old LFSR value, and the LFSR equals the loaded seed afterwards.
